// File: rtl/buzzer_tone_driver.sv
// Piezo buzzer driver: picks the highest active buzzer channel and drives a
// channel-specific square-wave tone, gated into a repeating ON/OFF beep cadence.
// All outputs are derived from flops only; buzz_en never reaches them combinationally.
module buzzer_tone_driver #(
    parameter int DIV1     = 12,
    parameter int DIV2     = 8,
    parameter int DIV3     = 5,
    parameter int BEEP_ON  = 24,
    parameter int BEEP_OFF = 12,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [2:0]   buzz_en,
    output logic         tone_p,
    output logic         tone_n,
    output logic         active,
    output logic [1:0]   chan
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Terminal counts: each phase lasts N cycles, so counters wrap at N-1.
    localparam logic [W-1:0] DIV1_LAST = W'(DIV1 - 1);
    localparam logic [W-1:0] DIV2_LAST = W'(DIV2 - 1);
    localparam logic [W-1:0] DIV3_LAST = W'(DIV3 - 1);
    localparam logic [W-1:0] ON_LAST   = W'(BEEP_ON - 1);
    localparam logic [W-1:0] OFF_LAST  = W'(BEEP_OFF - 1);

    state_t       state, state_nx;
    logic [1:0]   chan_nx;
    logic         tone_nx;
    logic [W-1:0] div_cnt, div_nx;
    logic [W-1:0] cad_cnt, cad_nx;
    logic [1:0]   sel;
    logic [W-1:0] div_last;

    // Highest-numbered active buzzer wins.
    always_comb begin
        if (buzz_en[2])      sel = 2'd3;
        else if (buzz_en[1]) sel = 2'd2;
        else if (buzz_en[0]) sel = 2'd1;
        else                 sel = 2'd0;
    end

    // Half-period terminal count for the channel currently sounding.
    always_comb begin
        case (chan)
            2'd2:    div_last = DIV2_LAST;
            2'd3:    div_last = DIV3_LAST;
            default: div_last = DIV1_LAST;
        endcase
    end

    // State and datapath registers; reset beats the clock enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            chan    <= 2'd0;
            tone_p  <= 1'b0;
            div_cnt <= '0;
            cad_cnt <= '0;
        end else if (ena) begin
            state   <= state_nx;
            chan    <= chan_nx;
            tone_p  <= tone_nx;
            div_cnt <= div_nx;
            cad_cnt <= cad_nx;
        end
    end

    // Next state: release > channel change > normal cadence sequencing.
    always_comb begin
        state_nx = state;
        chan_nx  = chan;
        tone_nx  = tone_p;
        div_nx   = div_cnt;
        cad_nx   = cad_cnt;
        case (state)
            IDLE: begin
                if (sel != 2'd0) begin
                    state_nx = ON;
                    chan_nx  = sel;
                    tone_nx  = 1'b1;
                    div_nx   = '0;
                    cad_nx   = '0;
                end
            end
            ON, OFF: begin
                if (sel == 2'd0) begin
                    state_nx = IDLE;
                    chan_nx  = 2'd0;
                    tone_nx  = 1'b0;
                    div_nx   = '0;
                    cad_nx   = '0;
                end else if (sel != chan) begin
                    // Restart immediately at the new pitch, mid-phase or not.
                    state_nx = ON;
                    chan_nx  = sel;
                    tone_nx  = 1'b1;
                    div_nx   = '0;
                    cad_nx   = '0;
                end else if (state == ON) begin
                    if (cad_cnt == ON_LAST) begin
                        // End of beep wins over a coincident divider toggle.
                        state_nx = OFF;
                        tone_nx  = 1'b0;
                        div_nx   = '0;
                        cad_nx   = '0;
                    end else begin
                        cad_nx = cad_cnt + W'(1);
                        if (div_cnt == div_last) begin
                            tone_nx = ~tone_p;
                            div_nx  = '0;
                        end else begin
                            div_nx  = div_cnt + W'(1);
                        end
                    end
                end else begin
                    if (cad_cnt == OFF_LAST) begin
                        state_nx = ON;
                        tone_nx  = 1'b1;
                        div_nx   = '0;
                        cad_nx   = '0;
                    end else begin
                        cad_nx = cad_cnt + W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                chan_nx  = 2'd0;
                tone_nx  = 1'b0;
                div_nx   = '0;
                cad_nx   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        active = (state != IDLE);
        tone_n = (state == ON) & ~tone_p;
    end

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Bench for buzzer_tone_driver: expected output words are computed from the
// cadence arithmetic, queued as stimulus is driven, popped after each edge.
`timescale 1ns/1ps
module tb_buzzer_tone_driver;

    localparam int D1 = 12, D2 = 8, D3 = 5, BON = 24, BOFF = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [2:0] buzz_en = 3'b000;
    logic       tone_p, tone_n, active;
    logic [1:0] chan;

    int         vectors = 0;
    int         miscompares = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got, e;

    buzzer_tone_driver #(
        .DIV1(D1), .DIV2(D2), .DIV3(D3), .BEEP_ON(BON), .BEEP_OFF(BOFF), .W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .buzz_en(buzz_en),
        .tone_p(tone_p), .tone_n(tone_n), .active(active), .chan(chan)
    );

    always #5 clk = ~clk;

    // Expected {tone_p, tone_n, active, chan} k cycles after entering ON (k=1 first).
    function automatic logic [4:0] cad_exp(int k, int div, logic [1:0] ch);
        int   pos;
        logic tp;
        pos = (k - 1) % (BON + BOFF);
        if (pos < BON) begin
            tp = (((pos / div) % 2) == 0);
            return {tp, ~tp, 1'b1, ch};
        end
        return {2'b00, 1'b1, ch};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; buzz_en = 3'b111;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(5'b0);
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset_hold i=%0d got %b want %b", i, got, e); end
        end
        rst_n = 1'b1; buzz_en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b0);
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset_idle i=%0d got %b want %b", i, got, e); end
        end
    endtask

    task automatic test_chan1();
        buzz_en = 3'b001;
        for (int k = 1; k <= 50; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL chan1 k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL chan1_release got %b want %b", got, e); end
    endtask

    task automatic test_chan3();
        buzz_en = 3'b100;
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back(cad_exp(k, D3, 2'd3));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL chan3 k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL chan3_release got %b want %b", got, e); end
    endtask

    task automatic test_priority();
        buzz_en = 3'b001;
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL prio_ch1 k=%0d got %b want %b", k, got, e); end
        end
        // Now in OFF; a higher channel appears and must restart immediately.
        buzz_en = 3'b011;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) buzz_en = 3'b010;   // same winner, must not restart
            exp_q.push_back(cad_exp(k, D2, 2'd2));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL prio_ch2 k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL prio_release got %b want %b", got, e); end
    endtask

    task automatic test_back_to_back();
        buzz_en = 3'b001;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL b2b_ch1 k=%0d got %b want %b", k, got, e); end
        end
        // Mid-ON switch to channel 3, then a pattern change that keeps 3 on top.
        buzz_en = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            if (k == 13) buzz_en = 3'b101;
            exp_q.push_back(cad_exp(k, D3, 2'd3));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL b2b_ch3 k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL b2b_release got %b want %b", got, e); end
    endtask

    task automatic test_release_mid();
        buzz_en = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rel_pre k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b0);
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rel_idle i=%0d got %b want %b", i, got, e); end
        end
        buzz_en = 3'b001;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rel_again k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rel_end got %b want %b", got, e); end
    endtask

    task automatic test_ena_reset();
        buzz_en = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL ena_pre k=%0d got %b want %b", k, got, e); end
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(cad_exp(8, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL ena_hold i=%0d got %b want %b", i, got, e); end
        end
        ena = 1'b1;
        for (int k = 9; k <= 40; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL ena_post k=%0d got %b want %b", k, got, e); end
        end
        // Reset mid-beep with ena low: reset must still win.
        rst_n = 1'b0; ena = 1'b0;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rst_mid got %b want %b", got, e); end
        rst_n = 1'b1; ena = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(cad_exp(k, D1, 2'd1));
            tick();
            got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rst_restart k=%0d got %b want %b", k, got, e); end
        end
        buzz_en = 3'b000;
        exp_q.push_back(5'b0);
        tick();
        got = {tone_p, tone_n, active, chan}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rst_end got %b want %b", got, e); end
    endtask

    initial begin
        test_reset();
        test_chan1();
        test_chan3();
        test_priority();
        test_back_to_back();
        test_release_mid();
        test_ena_reset();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain left %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_driver.md
# buzzer_tone_driver

Downstream stage of the sensor-alarm block. Converts the three buzzer-enable levels that block produces (`buzzer1..3`, one per sensor) into a single piezo drive: a square-wave tone whose pitch identifies the channel, gated into a repeating beep cadence. Highest-numbered active channel wins. Outputs go straight to `uo_out` pins, as a differential pair plus status.

## Interface
- `DIV1`, default 12: tone half-period in clocks for channel 1.
- `DIV2`, default 8: tone half-period in clocks for channel 2.
- `DIV3`, default 5: tone half-period in clocks for channel 3.
- `BEEP_ON`, default 24: length of the tone-on phase in clocks.
- `BEEP_OFF`, default 12: length of the silent phase in clocks.
- `W`, default 8: counter width. All of `DIV1..3`, `BEEP_ON` and `BEEP_OFF` are at least 1 and at most 2^W−1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  clock enable. When low, all state is frozen.
- `buzz_en`  in  3  bit n−1 carries upstream buzzer n's level, synchronous to `clk`.
- `tone_p`  out  1  piezo drive, positive.
- `tone_n`  out  1  piezo drive, negative. Equals ~`tone_p` while ON; 0 otherwise.
- `active`  out  1  high in ON or OFF state.
- `chan`  out  2  channel being sounded: 0 = none, 1..3.

## Operation
- Reset (`rst_n` low at a rising edge; takes priority over `ena`):
  - state IDLE;
  - `tone_p`, `tone_n` and `active` = 0;
  - `chan` = 0;
  - both counters = 0.
- When `ena` is low and `rst_n` is high, nothing changes and the outputs hold.
- Selection, combinational: `sel` = 3 if `buzz_en[2]`, else 2 if `buzz_en[1]`, else 1 if `buzz_en[0]`, else 0. `DIVsel` is the half-period parameter for `sel`.
- States:
  - **IDLE:**
    - If `sel` ≠ 0, go to ON: `chan` ← `sel`, `tone_p` ← 1, `div_cnt` ← 0, `cad_cnt` ← 0.
  - **ON:**
    - `div_cnt` increments each cycle. When `div_cnt` = `DIVchan`−1, `tone_p` toggles and `div_cnt` ← 0.
    - `cad_cnt` increments each cycle. When `cad_cnt` = `BEEP_ON`−1, go to OFF: `tone_p` ← 0, `cad_cnt` ← 0.
  - **OFF:**
    - Tone is silent.
    - When `cad_cnt` = `BEEP_OFF`−1, re-enter ON with `tone_p` ← 1 and both counters cleared.
- Priority of events within one cycle, highest first:
  1. `sel` = 0 while ON or OFF: go to IDLE. All outputs become 0 and the counters clear.
  2. `sel` ≠ `chan` while ON or OFF: restart in ON with `chan` ← `sel`, `tone_p` ← 1 and the counters cleared. This restart does not wait for the current phase to end.
  3. Normal ON/OFF sequencing.
- Truncation: if `BEEP_ON` is not a multiple of `DIVchan`, the last tone half-cycle is truncated. Cadence ends take precedence over a divider toggle in the same cycle.
- Reset asserted mid-beep returns everything to the reset values at that edge.

## Timing
- Latency: `buzz_en` goes nonzero before edge k → `tone_p` = 1, `active` = 1 and `chan` valid after edge k (one cycle).
- Tone period is 2·`DIVchan` clocks at 50% duty, with the first half-period high.
- Cadence period is `BEEP_ON` + `BEEP_OFF` clocks. `tone_p` is exactly 0 for `BEEP_OFF` cycles.
- Release: `buzz_en` goes to 0 before edge k → all outputs 0 after edge k.
- Channel change: new `sel` seen at edge k → new pitch starts high after edge k.
- `tone_n` and `tone_p` are never both 1.
- All outputs are registered. No combinational path exists from `buzz_en` to the outputs.

## Test plan
- **Reset:** hold `rst_n` low 2 cycles with `buzz_en`=3'b111 and `ena`=1 → all outputs 0. Then release with `buzz_en`=0 → outputs stay 0.
- **Channel 1 cadence (defaults):** `buzz_en`=3'b001 from edge 1 → after edge 1, `chan`=1 and `active`=1.
  - `tone_p` high for edges 1–12, low for edges 13–24.
  - Silent (`tone_p`=`tone_n`=0) for edges 25–36.
  - High again from edge 37.
- **Channel 3 truncation:** `buzz_en`=3'b100 → `tone_p` pattern in ON is 5H 5L 5H 5L 4H, then 12 silent cycles. `chan`=3. `tone_n` is the complement only during ON.
- **Priority and change:** start with 3'b001. At cycle 30 (in OFF), set 3'b011 → next edge `chan`=2, `tone_p`=1, half-period 8. Then set 3'b010 → no restart.
- **Release mid-tone:** set `buzz_en`=0 at cycle 6 of ON → after the next edge, all outputs are 0 and the state is IDLE. Re-assert 3'b001 → tone restarts high with a full 12-cycle half-period.
- **`ena` freeze and reset mid-beep:**
  - Drop `ena` for 5 cycles during ON → outputs and counters hold, and the timeline shifts by exactly 5 cycles.
  - Pulse `rst_n` low mid-beep → outputs are 0 after that edge.
